// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// fault cause encodings and the instruction size.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_RANGE    = 2'd2;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register. Next pc is the redirect target, pc+INSTR_BYTES or a hold,
// chosen by FSM strobes. pc is visible one edge after a strobe, with no input-to-output path.
module fetch_pc_reg #(
  parameter int                  ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_inc,
  input  logic                  pc_redir,
  input  logic [ADDR_WIDTH-1:0] redir_target,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_d, pc_q;

  // Redirect wins over increment; the FSM never raises both, but the order is explicit.
  always_comb begin
    pc_d = pc_q;
    if (pc_redir) begin
      pc_d = redir_target;
    end else if (pc_inc) begin
      pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches 32-bit words from zero-latency program memory into a valid/ready fetch register,
// one per cycle; stalls with all state held when decode backpressures; sticky faults on bad fetches.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    MEM_BYTES  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] pc_out,
  input  logic [31:0]           instr_in,
  output logic [31:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  output logic [31:0]           fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEM_BYTES - INSTR_BYTES);

  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_chk
    $error("RESET_PC must be instruction aligned");
  end

  fetch_state_t          state_d, state_q;
  logic [31:0]           instr_d, instr_q;
  logic [ADDR_WIDTH-1:0] instr_pc_d, instr_pc_q;
  logic                  valid_d, valid_q;
  logic                  fault_d, fault_q;
  logic [1:0]            cause_d, cause_q;
  logic [31:0]           count_d, count_q;
  logic                  pc_inc, pc_redir;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  load_ok;

  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC),
    .INSTR_BYTES(INSTR_BYTES)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .pc_inc      (pc_inc),
    .pc_redir    (pc_redir),
    .redir_target(redirect_target),
    .pc          (pc)
  );

  assign load_ok = !valid_q || instr_ready;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    count_d    = count_q;
    pc_inc     = 1'b0;
    pc_redir   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          state_d = FAULT;
          fault_d = 1'b1;
          cause_d = FC_MISALIGN;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          // Flush even an unaccepted word so decode only sees target-path instructions.
          valid_d  = 1'b0;
          pc_redir = 1'b1;
        end else if ((pc > LAST_PC) && load_ok) begin
          state_d = FAULT;
          fault_d = 1'b1;
          cause_d = FC_RANGE;
          if (instr_ready) valid_d = 1'b0;
        end else if (load_ok) begin
          instr_d    = instr_in;
          instr_pc_d = pc;
          valid_d    = 1'b1;
          pc_inc     = 1'b1;
          count_d    = count_q + 32'd1;
        end
      end
      FAULT: begin
        if (instr_ready) valid_d = 1'b0;
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= FC_NONE;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
    end
  end

  assign pc_out      = pc;
  assign instr_out   = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: byte i of program memory holds value i,
// so the big-endian word at address a is {a, a+1, a+2, a+3}.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic [7:0] mem [0:99];
  initial for (int i = 0; i < 100; i++) mem[i] = 8'(i);

  always_comb begin
    if (pc_out <= 32'd96)
      instr_in = {mem[pc_out[6:0]], mem[pc_out[6:0] + 7'd1], mem[pc_out[6:0] + 7'd2], mem[pc_out[6:0] + 7'd3]};
    else
      instr_in = 32'hDEAD_BEEF;
  end

  instruction_fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0),
    .MEM_BYTES (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .instr_in       (instr_in),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    do_reset();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // Streaming fetch and a 5-cycle stall after the first capture.
    instr_ready = 1'b1;
    step();
    chk("cap0_instr", instr_out, 32'h0001_0203);
    chk("cap0_pc", instr_pc, 32'h0);
    chk("cap0_valid", {31'b0, instr_valid}, 32'd1);
    chk("cap0_pcout", pc_out, 32'h4);
    instr_ready = 1'b0;
    step(5);
    chk("stall_instr", instr_out, 32'h0001_0203);
    chk("stall_ipc", instr_pc, 32'h0);
    chk("stall_pcout", pc_out, 32'h4);
    chk("stall_count", fetch_count, 32'd1);
    instr_ready = 1'b1;
    step();
    chk("cap4_instr", instr_out, 32'h0405_0607);
    chk("cap4_pc", instr_pc, 32'h4);
    step();
    chk("cap8_instr", instr_out, 32'h0809_0A0B);
    chk("cap8_count", fetch_count, 32'd3);

    // Redirect while stalled flushes the unaccepted word.
    instr_ready = 1'b0;
    step();
    chk("stall2_ipc", instr_pc, 32'h8);
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    step();
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_pcout", pc_out, 32'h20);
    chk("redir_count", fetch_count, 32'd3);
    redirect_valid = 1'b0;
    step();
    chk("tgt_ipc", instr_pc, 32'h20);
    chk("tgt_instr", instr_out, 32'h2021_2223);
    chk("tgt_count", fetch_count, 32'd4);

    // Redirect coinciding with an accepted handshake.
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    step();
    chk("redir2_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir2_pcout", pc_out, 32'h40);
    redirect_valid = 1'b0;
    step();
    chk("tgt2_instr", instr_out, 32'h4041_4243);
    chk("tgt2_count", fetch_count, 32'd5);

    // Misaligned redirect: sticky fault, later redirects ignored.
    redirect_valid  = 1'b1;
    redirect_target = 32'h22;
    step();
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_cause", {30'b0, fault_cause}, 32'd1);
    chk("mis_valid", {31'b0, instr_valid}, 32'd0);
    chk("mis_pcout", pc_out, 32'h44);
    redirect_target = 32'h10;
    step();
    redirect_valid = 1'b0;
    step();
    chk("mis_ign_pc", pc_out, 32'h44);
    chk("mis_ign_cause", {30'b0, fault_cause}, 32'd1);
    chk("mis_ign_count", fetch_count, 32'd5);
    do_reset();
    chk("mis_rst_pc", pc_out, 32'h0);
    chk("mis_rst_fault", {31'b0, fault}, 32'd0);
    chk("mis_rst_cause", {30'b0, fault_cause}, 32'd0);

    // Run off the end of memory.
    redirect_valid  = 1'b1;
    redirect_target = 32'd88;
    step();
    redirect_valid = 1'b0;
    step(3);
    chk("end_instr", instr_out, 32'h6061_6263);
    chk("end_ipc", instr_pc, 32'd96);
    chk("end_pcout", pc_out, 32'd100);
    chk("end_count", fetch_count, 32'd3);
    step();
    chk("rng_fault", {31'b0, fault}, 32'd1);
    chk("rng_cause", {30'b0, fault_cause}, 32'd2);
    chk("rng_valid", {31'b0, instr_valid}, 32'd0);
    step(3);
    chk("rng_count", fetch_count, 32'd3);
    chk("rng_pcout", pc_out, 32'd100);
    chk("rng_ipc", instr_pc, 32'd96);

    // Reset in the middle of a stall.
    do_reset();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step(2);
    chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("srst_valid", {31'b0, instr_valid}, 32'd0);
    chk("srst_instr", instr_out, 32'h0);
    chk("srst_ipc", instr_pc, 32'h0);
    chk("srst_pcout", pc_out, 32'h0);
    chk("srst_count", fetch_count, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Upstream neighbour of the program memory. Owns the program counter and drives the memory's byte address. Registers the returned 32-bit big-endian instruction word into a fetch register with a valid/ready handshake toward decode. Handles branch/jump redirects with flush, backpressure stalls, and sticky faults for misaligned or out-of-range fetches.

Parameters:
ADDR_WIDTH, 32, width of PC and byte address
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_BYTES, 100, size of program memory in bytes; last legal fetch address is MEM_BYTES-4
INSTR_BYTES, 4, bytes per instruction and PC increment

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
pc_out  output  ADDR_WIDTH  current PC, wired to program memory Counter_value
instr_in  input  32  Instruction_code from program memory, combinational on pc_out
instr_out  output  32  registered instruction to decode
instr_pc  output  ADDR_WIDTH  byte address instr_out was fetched from
instr_valid  output  1  instr_out/instr_pc hold a live instruction
instr_ready  input  1  decode accepts instr_out this cycle when instr_valid=1
redirect_valid  input  1  branch/jump taken; flush and refetch from redirect_target
redirect_target  input  ADDR_WIDTH  new PC for redirect
fault  output  1  sticky fault indicator
fault_cause  output  2  0=none, 1=misaligned redirect, 2=PC out of range
fetch_count  output  32  number of instructions captured into fetch register since reset

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, fault=0, fault_cause=0, fetch_count=0, state=FETCH. rst has priority over all other inputs, including mid-stall and in FAULT.
- pc_out = pc register directly (no combinational path from inputs).
- Memory latency is zero: instr_in is sampled at the same edge that pc_out presented it.
- load_ok = !instr_valid || instr_ready.
- States: FETCH, FAULT.
- FETCH, priority order each edge:
  1. redirect_valid=1, redirect_target[1:0]!=0: go FAULT, fault=1, fault_cause=1, instr_valid<=0. pc is unchanged.
  2. redirect_valid=1, target aligned: instr_valid<=0 (flush, even if unaccepted), pc<=redirect_target. No capture this edge. This holds regardless of instr_ready.
  3. pc > MEM_BYTES-4 and load_ok: go FAULT, fault=1, fault_cause=2. instr_valid<=0 if instr_ready, else held.
  4. load_ok: instr_out<=instr_in, instr_pc<=pc, instr_valid<=1, pc<=pc+INSTR_BYTES (mod 2^ADDR_WIDTH), fetch_count+=1.
  5. Otherwise (instr_valid=1, instr_ready=0), stall: all registers hold, pc_out stable.
- Throughput: one instruction per cycle while instr_ready=1 and no redirect.
- A redirect arriving with instr_valid=1 and instr_ready=1 in the same cycle: the handshake completes for decode; the fetch unit still flushes, so the next instruction is from the target.
- FAULT: absorbing until rst. redirect_valid is ignored. There are no captures and pc holds. A pending instr_valid drops once instr_ready=1. fault and fault_cause remain stable.
- fetch_count wraps at 2^32 silently.
- The misaligned check applies only to redirects. RESET_PC must be aligned; this is a parameter rule, checked by an elaboration assertion.

Decomposition:
- Package fetch_pkg: state enum {FETCH, FAULT}, fault cause constants FC_NONE=0, FC_MISALIGN=1, FC_RANGE=2, INSTR_BYTES.
- One natural sub-module, fetch_pc_reg: holds pc and computes next-pc (increment / redirect / hold) from control strobes supplied by the FSM.
- The FSM, output register and counter stay in the top.

Test Plan:
- Reset then instr_ready=1 constantly with memory bytes 00..0F loaded -> instr_out=32'h00010203 @pc 0, 32'h04050607 @pc 4, and so on, one per cycle; fetch_count=3 after 3 captures.
- Hold instr_ready=0 for 5 cycles after the first capture -> instr_out, instr_pc=0 and pc_out=4 all stable; on release the next capture is pc=4.
- redirect_valid=1, target=0x20, while instr_valid=1 and instr_ready=0 -> next cycle instr_valid=0 and pc_out=0x20; the following cycle instr_pc=0x20.
- redirect target=0x22 -> fault=1, fault_cause=1, instr_valid=0; a later redirect to 0x10 is ignored; rst restores pc_out=0 and fault=0.
- Sequential run to pc=96 with MEM_BYTES=100 -> capture @96 succeeds, then pc=100 -> fault_cause=2 and no further captures.
- Assert rst during a stall with instr_valid=1 -> next cycle all outputs at reset values, fetch_count=0.
